// File: rtl/gamepad_poller.sv
// Serial gamepad reader: drives latch/pulse to NUM_PADS pads in parallel (NES/SNES style)
// and presents a registered snapshot of every pad's buttons with a one-cycle valid strobe.
module gamepad_poller #(
    parameter int NUM_PADS        = 1,
    parameter int NUM_BITS        = 8,
    parameter int HALF_PERIOD     = 100,
    parameter int POLL_INTERVAL   = 550000,
    parameter int ACTIVE_LOW_DATA = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         poll_now,
    input  logic [NUM_PADS-1:0]          data,
    output logic                         latch,
    output logic                         pulse,
    output logic [NUM_PADS*NUM_BITS-1:0] buttons,
    output logic                         valid,
    output logic                         busy
);

    localparam int POLL_LEN = 2 * HALF_PERIOD * NUM_BITS + 1;
    localparam int CNT_MAX  = (POLL_INTERVAL > POLL_LEN) ? POLL_INTERVAL : POLL_LEN;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int PH_W     = $clog2(2 * HALF_PERIOD);
    localparam int BI_W     = $clog2(NUM_BITS);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        PULSE_HI,
        PULSE_LO,
        DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            interval_q;
    logic [PH_W-1:0]             phase_q, phase_d;
    logic [BI_W-1:0]             bit_q, bit_d;
    logic                        pending_q;
    logic                        start, due, sample_en;
    logic [NUM_PADS-1:0]         data_p0, data_p1;
    logic [NUM_BITS-1:0]         shift_q [NUM_PADS];
    logic                        latch_q, pulse_q, busy_q, valid_q;
    logic [NUM_PADS*NUM_BITS-1:0] buttons_q;

    assign due     = (interval_q == CNT_W'(POLL_INTERVAL - 1));
    assign latch   = latch_q;
    assign pulse   = pulse_q;
    assign busy    = busy_q;
    assign valid   = valid_q;
    assign buttons = buttons_q;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q + 1'b1;
        bit_d     = bit_q;
        start     = 1'b0;
        sample_en = 1'b0;
        case (state_q)
            IDLE: begin
                phase_d = '0;
                if (pending_q || due) begin
                    start   = 1'b1;
                    state_d = LATCH;
                end
            end
            LATCH: begin
                if (phase_q == PH_W'(2 * HALF_PERIOD - 1)) begin
                    sample_en = 1'b1;
                    state_d   = PULSE_HI;
                    phase_d   = '0;
                    bit_d     = BI_W'(1);
                end
            end
            PULSE_HI: begin
                if (phase_q == PH_W'(HALF_PERIOD - 1)) begin
                    sample_en = 1'b1;
                    state_d   = PULSE_LO;
                    phase_d   = '0;
                end
            end
            PULSE_LO: begin
                if (phase_q == PH_W'(HALF_PERIOD - 1)) begin
                    phase_d = '0;
                    if (bit_q == BI_W'(NUM_BITS - 1)) begin
                        state_d = DONE;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        state_d = PULSE_HI;
                    end
                end
            end
            DONE: begin
                // A request that arrived mid-poll chains straight into the next latch.
                phase_d = '0;
                if (pending_q || due) begin
                    start   = 1'b1;
                    state_d = LATCH;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_p0    <= '0;
            data_p1    <= '0;
            state_q    <= IDLE;
            phase_q    <= '0;
            bit_q      <= '0;
            interval_q <= '0;
            pending_q  <= 1'b0;
            latch_q    <= 1'b0;
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            buttons_q  <= '0;
            for (int p = 0; p < NUM_PADS; p++) begin
                shift_q[p] <= '0;
            end
        end else begin
            // Two-flop synchroniser for the asynchronous pad data lines.
            data_p0    <= data;
            data_p1    <= data_p0;
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            interval_q <= start ? '0 : interval_q + 1'b1;
            pending_q  <= start ? 1'b0 : (pending_q | poll_now | due);
            // Strobes are registered copies of the next state so the pad pins never glitch.
            latch_q    <= (state_d == LATCH);
            pulse_q    <= (state_d == PULSE_HI);
            busy_q     <= (state_d == LATCH) || (state_d == PULSE_HI) || (state_d == PULSE_LO);
            valid_q    <= (state_d == DONE);
            if (sample_en) begin
                for (int p = 0; p < NUM_PADS; p++) begin
                    shift_q[p] <= {data_p1[p], shift_q[p][NUM_BITS-1:1]};
                end
            end
            if (state_d == DONE) begin
                for (int p = 0; p < NUM_PADS; p++) begin
                    if (ACTIVE_LOW_DATA != 0) begin
                        buttons_q[p*NUM_BITS +: NUM_BITS] <= ~shift_q[p];
                    end else begin
                        buttons_q[p*NUM_BITS +: NUM_BITS] <= shift_q[p];
                    end
                end
            end
        end
    end

endmodule
